// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter sharing the usb_cdc_core device->host byte stream between NUM_REQ requesters.
// Optional build macro CDC_ARB_PRIO_EN: requester 0 gets fixed priority at each new grant.
module cdc_tx_arbiter #(
    parameter int         NUM_REQ     = 2,
    parameter int         MAX_BURST   = 16,
    parameter logic [7:0] EOP_BYTE    = 8'h0A,
    parameter int         GAP_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_accept_o,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    input  logic                 out_accept_i,
    output logic [NUM_REQ-1:0]   grant_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
`ifdef CDC_ARB_PRIO_EN
    logic [IDX_W-1:0] last_low_q, last_low_d;
`endif

    logic [NUM_REQ-1:0] grant_vec;
    logic               g_valid;
    logic [7:0]         g_byte;
    logic               xfer;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    // Granted requester decode: grant vector, its valid and its byte.
    always_comb begin
        grant_vec = '0;
        g_byte    = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == S_GRANT && last_grant_q == IDX_W'(i)) begin
                grant_vec[i] = 1'b1;
                g_byte       = req_data_i[8*i +: 8];
            end
        end
    end

    assign g_valid      = |(req_valid_i & grant_vec);
    assign req_accept_o = grant_vec & req_valid_i & {NUM_REQ{~out_valid_q | out_accept_i}};
    assign xfer         = |req_accept_o;
    assign grant_o      = grant_vec;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;

    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
`ifdef CDC_ARB_PRIO_EN
        // Requester 0 wins whenever valid, except right after its own grant when others are waiting.
        if (req_valid_i[0] && last_grant_q != '0) begin
            pick_valid = 1'b1;
        end else begin
            for (int off = 1; off < NUM_REQ; off++) begin
                idx = 1 + ((int'(last_low_q) - 1 + off) % (NUM_REQ - 1));
                if (!pick_valid && req_valid_i[IDX_W'(idx)]) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDX_W'(idx);
                end
            end
            if (!pick_valid && req_valid_i[0]) begin
                pick_valid = 1'b1;
            end
        end
`else
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant_q) + off) % NUM_REQ;
            if (!pick_valid && req_valid_i[IDX_W'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
`ifdef CDC_ARB_PRIO_EN
        last_low_d   = last_low_q;
`endif

        // The output stage drains independently of the arbitration state.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = g_byte;
        end else if (out_accept_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i && pick_valid) begin
                    state_d      = S_GRANT;
                    last_grant_d = pick_idx;
                    burst_cnt_d  = 8'd0;
                    gap_cnt_d    = 16'd0;
`ifdef CDC_ARB_PRIO_EN
                    if (pick_idx != '0) begin
                        last_low_d = pick_idx;
                    end
`endif
                end
            end
            S_GRANT: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
                gap_cnt_d = g_valid ? 16'd0 : gap_cnt_q + 16'd1;
                if ((xfer && (g_byte == EOP_BYTE || burst_cnt_q == 8'(MAX_BURST - 1))) ||
                    (!g_valid && gap_cnt_q == 16'(GAP_TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q  <= 8'd0;
            gap_cnt_q    <= 16'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
`ifdef CDC_ARB_PRIO_EN
            last_low_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
`ifdef CDC_ARB_PRIO_EN
            last_low_q   <= last_low_d;
`endif
        end
    end

endmodule
